// File: rtl/fp_unit_sequencer_if.sv
// ---------------------------------------------------------------------------
// fp_unit_sequencer_if
//   Bundles every non-clock signal of the FP unit sequencer. It covers the
//   request channel from issue, the operand/start/flush fan-out to the FP
//   datapath units, and their results coming back. It also carries the
//   response channel and the sticky flag accumulator.
//
//   Handshake rule (both request and response channels): a transfer happens
//   on a rising clk edge where valid && ready are both high. Once valid is
//   raised, the sender holds valid and payload stable until that transfer.
//   ready may depend combinationally on the receiver's state.
//
//   reqUnit / opUnit encoding (FpUnitType):
//     0 Move, 1 Classifier, 2 Sign, 3 Comparator, 4 MulAdd, 5 Div,
//     6 Sqrt, 7 unknown / unsupported.
//
//   Modports:
//     slave  - the sequencer
//     master - issue stage + datapath units + response consumer
// ---------------------------------------------------------------------------
interface fp_unit_sequencer_if #(
  parameter int FLEN = 32,
  parameter int XLEN = 32
);
  // request channel
  logic            reqValid;
  logic            reqReady;
  logic [2:0]      reqUnit;
  logic [2:0]      reqRm;
  logic [FLEN-1:0] reqSrc1;
  logic [FLEN-1:0] reqSrc2;
  logic [FLEN-1:0] reqSrc3;
  logic [XLEN-1:0] reqIntSrc;
  logic            flush;
  // datapath unit side
  logic            unitStart;
  logic            unitFlush;
  logic [2:0]      opUnit;
  logic [2:0]      opRm;
  logic [FLEN-1:0] opSrc1;
  logic [FLEN-1:0] opSrc2;
  logic [FLEN-1:0] opSrc3;
  logic [XLEN-1:0] opIntSrc;
  logic            unitDone;
  logic [FLEN-1:0] unitFpResult;
  logic [XLEN-1:0] unitIntResult;
  logic [4:0]      unitFlags;
  logic            unitWriteFlags;
  // response channel
  logic            rspValid;
  logic            rspReady;
  logic [FLEN-1:0] rspFpResult;
  logic [XLEN-1:0] rspIntResult;
  logic [4:0]      rspFlags;
  logic            rspWriteFlags;
  // flag accumulator
  logic            clearFlags;
  logic [4:0]      fflagsAcc;

  modport slave (
    input  reqValid, reqUnit, reqRm, reqSrc1, reqSrc2, reqSrc3, reqIntSrc,
           flush, unitDone, unitFpResult, unitIntResult, unitFlags,
           unitWriteFlags, rspReady, clearFlags,
    output reqReady, unitStart, unitFlush, opUnit, opRm, opSrc1, opSrc2,
           opSrc3, opIntSrc, rspValid, rspFpResult, rspIntResult, rspFlags,
           rspWriteFlags, fflagsAcc
  );

  modport master (
    output reqValid, reqUnit, reqRm, reqSrc1, reqSrc2, reqSrc3, reqIntSrc,
           flush, unitDone, unitFpResult, unitIntResult, unitFlags,
           unitWriteFlags, rspReady, clearFlags,
    input  reqReady, unitStart, unitFlush, opUnit, opRm, opSrc1, opSrc2,
           opSrc3, opIntSrc, rspValid, rspFpResult, rspIntResult, rspFlags,
           rspWriteFlags, fflagsAcc
  );
endinterface

// File: rtl/fp_unit_sequencer.sv
// ---------------------------------------------------------------------------
// fp_unit_sequencer
//   Accepts one FP operation at a time and latches its operands. It then
//   pulses unitStart and waits for completion. Completion is a fixed
//   latency (down-counter) or, for Sqrt, the unitDone strobe. The unit
//   outputs are captured into response registers and presented on the
//   response channel, and accepted flags are OR-ed into a sticky
//   accumulator.
//
//   Ports:
//     clk          clock
//     rst          asynchronous active-low reset
//     bus          fp_unit_sequencer_if.slave (request, unit, response,
//                  flag accumulator signals)
//     dbg_state_o  current FSM state (0 IDLE, 1 EXEC, 2 WAIT_DONE, 3 RESP)
// ---------------------------------------------------------------------------
module fp_unit_sequencer #(
  parameter int FLEN          = 32,
  parameter int XLEN          = 32,
  parameter int MULADD_CYCLES = 3,
  parameter int DIV_CYCLES    = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_unit_sequencer_if.slave   bus,
  output logic [1:0]           dbg_state_o
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_EXEC      = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_RESP      = 2'd3;

  localparam logic [2:0] U_MULADD  = 3'd4;
  localparam logic [2:0] U_DIV     = 3'd5;
  localparam logic [2:0] U_SQRT    = 3'd6;
  localparam logic [2:0] U_UNKNOWN = 3'd7;

  localparam int MAX_LAT = (MULADD_CYCLES > DIV_CYCLES) ? MULADD_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            start_q;
  logic [2:0]      op_unit_q, op_rm_q;
  logic [FLEN-1:0] op_src1_q, op_src2_q, op_src3_q;
  logic [XLEN-1:0] op_int_q;
  logic [FLEN-1:0] rsp_fp_q;
  logic [XLEN-1:0] rsp_int_q;
  logic [4:0]      rsp_flags_q;
  logic            rsp_wf_q;
  logic [4:0]      acc_q, acc_d;

  logic accept, capture, rsp_hs, flush_act, known_unit;

  assign flush_act  = bus.flush && (state_q != S_IDLE);
  assign accept     = (state_q == S_IDLE) && bus.reqValid && !bus.flush;
  assign known_unit = (op_unit_q != U_UNKNOWN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    rsp_hs  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_EXEC;
          // Counter holds L-1 so that "counter == 0" marks the last cycle.
          case (bus.reqUnit)
            U_MULADD: cnt_d = CW'(MULADD_CYCLES - 1);
            U_DIV:    cnt_d = CW'(DIV_CYCLES - 1);
            default:  cnt_d = '0;
          endcase
        end
      end
      S_EXEC: begin
        if (op_unit_q == U_SQRT) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (bus.unitDone) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      default: begin // S_RESP
        if (bus.rspReady) begin
          rsp_hs  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
    // Flush overrides everything, including a response handshake in the
    // same cycle: that response is treated as dropped.
    if (flush_act) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      capture = 1'b0;
      rsp_hs  = 1'b0;
    end
  end

  always_comb begin
    acc_d = bus.clearFlags ? 5'd0 : acc_q;
    if (rsp_hs && rsp_wf_q) acc_d = acc_d | rsp_flags_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      op_unit_q   <= '0;
      op_rm_q     <= '0;
      op_src1_q   <= '0;
      op_src2_q   <= '0;
      op_src3_q   <= '0;
      op_int_q    <= '0;
      rsp_fp_q    <= '0;
      rsp_int_q   <= '0;
      rsp_flags_q <= '0;
      rsp_wf_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= accept;
      acc_q   <= acc_d;
      if (accept) begin
        op_unit_q <= bus.reqUnit;
        op_rm_q   <= bus.reqRm;
        op_src1_q <= bus.reqSrc1;
        op_src2_q <= bus.reqSrc2;
        op_src3_q <= bus.reqSrc3;
        op_int_q  <= bus.reqIntSrc;
      end
      if (capture) begin
        // Unsupported units answer with an all-zero, non-flag-writing result.
        rsp_fp_q    <= known_unit ? bus.unitFpResult   : '0;
        rsp_int_q   <= known_unit ? bus.unitIntResult  : '0;
        rsp_flags_q <= known_unit ? bus.unitFlags      : '0;
        rsp_wf_q    <= known_unit ? bus.unitWriteFlags : 1'b0;
      end
    end
  end

  assign bus.reqReady      = (state_q == S_IDLE) && !bus.flush;
  assign bus.unitStart     = start_q;
  assign bus.unitFlush     = flush_act;
  assign bus.opUnit        = op_unit_q;
  assign bus.opRm          = op_rm_q;
  assign bus.opSrc1        = op_src1_q;
  assign bus.opSrc2        = op_src2_q;
  assign bus.opSrc3        = op_src3_q;
  assign bus.opIntSrc      = op_int_q;
  assign bus.rspValid      = (state_q == S_RESP);
  assign bus.rspFpResult   = rsp_fp_q;
  assign bus.rspIntResult  = rsp_int_q;
  assign bus.rspFlags      = rsp_flags_q;
  assign bus.rspWriteFlags = rsp_wf_q;
  assign bus.fflagsAcc     = acc_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_fp_unit_sequencer.sv
module tb_fp_unit_sequencer;
  localparam int FLEN = 32;
  localparam int XLEN = 32;
  localparam int MULADD = 3;
  localparam int DIV = 14;

  localparam logic [2:0] U_MOVE   = 3'd0;
  localparam logic [2:0] U_CMP    = 3'd3;
  localparam logic [2:0] U_MULADD = 3'd4;
  localparam logic [2:0] U_DIV    = 3'd5;
  localparam logic [2:0] U_SQRT   = 3'd6;
  localparam logic [2:0] U_UNK    = 3'd7;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_unit_sequencer_if #(.FLEN(FLEN), .XLEN(XLEN)) bus ();
  logic [1:0] dbg_state;

  fp_unit_sequencer #(
    .FLEN(FLEN), .XLEN(XLEN), .MULADD_CYCLES(MULADD), .DIV_CYCLES(DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] acc_model = 5'd0;
  logic [31:0] sq_res;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are driven just after the falling edge, outputs checked 1 time
  // unit later: both well away from the rising edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_op(input logic [2:0] unit, input int lat, input logic [31:0] res,
                       input logic [4:0] flags, input logic wf, input logic clr);
    logic known;
    logic [31:0] e_res, e_int;
    logic [4:0] e_flags;
    logic e_wf;
    known   = (unit != U_UNK);
    e_res   = known ? res : 32'd0;
    e_int   = known ? ~res : 32'd0;
    e_flags = known ? flags : 5'd0;
    e_wf    = known ? wf : 1'b0;
    tick();
    bus.reqValid = 1'b1; bus.reqUnit = unit; bus.reqRm = 3'd2;
    bus.reqSrc1 = res ^ 32'h1; bus.reqSrc2 = res ^ 32'h2; bus.reqSrc3 = res ^ 32'h4;
    bus.reqIntSrc = res;
    bus.unitFpResult = res; bus.unitIntResult = ~res;
    bus.unitFlags = flags; bus.unitWriteFlags = wf; bus.rspReady = 1'b1;
    #1;
    check("req_ready_idle", bus.reqReady, 1);
    for (int i = 1; i <= lat; i++) begin
      tick();
      bus.reqValid = 1'b0;
      #1;
      check("unit_start", bus.unitStart, (i == 1));
      check("rsp_valid_early", bus.rspValid, 0);
      check("req_ready_busy", bus.reqReady, 0);
      if (i == 1) check("op_src1", bus.opSrc1, res ^ 32'h1);
    end
    tick();
    bus.clearFlags = clr;
    #1;
    check("rsp_valid", bus.rspValid, 1);
    check("req_ready_resp", bus.reqReady, 0);
    check("rsp_fp", bus.rspFpResult, e_res);
    check("rsp_int", bus.rspIntResult, e_int);
    check("rsp_flags", bus.rspFlags, e_flags);
    check("rsp_wf", bus.rspWriteFlags, e_wf);
    acc_model = (clr ? 5'd0 : acc_model) | (e_wf ? e_flags : 5'd0);
    tick();
    bus.clearFlags = 1'b0;
    #1;
    check("rsp_valid_done", bus.rspValid, 0);
    check("req_ready_after", bus.reqReady, 1);
    check("fflags_acc", bus.fflagsAcc, acc_model);
  endtask

  initial begin
    rst = 1'b0;
    bus.reqValid = 0; bus.reqUnit = 0; bus.reqRm = 0; bus.reqSrc1 = 0;
    bus.reqSrc2 = 0; bus.reqSrc3 = 0; bus.reqIntSrc = 0; bus.flush = 0;
    bus.unitDone = 0; bus.unitFpResult = 0; bus.unitIntResult = 0;
    bus.unitFlags = 0; bus.unitWriteFlags = 0; bus.rspReady = 0; bus.clearFlags = 0;

    // reset state
    repeat (3) tick();
    #1;
    check("rst_state", dbg_state, 0);
    check("rst_req_ready", bus.reqReady, 1);
    check("rst_rsp_valid", bus.rspValid, 0);
    check("rst_unit_start", bus.unitStart, 0);
    check("rst_unit_flush", bus.unitFlush, 0);
    check("rst_acc", bus.fflagsAcc, 0);
    tick(); rst = 1'b1;

    // Move: flags present but not written, so accumulator stays 0
    do_op(U_MOVE, 1, 32'h3F80_0000, 5'h1F, 1'b0, 1'b0);
    // Div with NX, then MulAdd with NV, then Comparator with OF + clear
    do_op(U_DIV, DIV, 32'h4049_0FDB, 5'h01, 1'b1, 1'b0);
    do_op(U_MULADD, MULADD, 32'hC000_0000, 5'h10, 1'b1, 1'b0);
    check("acc_0x11", bus.fflagsAcc, 5'h11);
    do_op(U_CMP, 1, 32'h0000_0001, 5'h04, 1'b1, 1'b1);
    check("acc_0x04", bus.fflagsAcc, 5'h04);

    // Flush mid-Div at T+5
    tick();
    bus.reqValid = 1'b1; bus.reqUnit = U_DIV; bus.unitFlags = 5'h08; bus.unitWriteFlags = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      bus.reqValid = 1'b0;
    end
    tick();
    bus.flush = 1'b1;
    #1;
    check("flush_unit_flush", bus.unitFlush, 1);
    check("flush_req_ready", bus.reqReady, 0);
    tick();
    bus.flush = 1'b0;
    #1;
    check("flush_state_idle", dbg_state, 0);
    check("flush_req_ready_after", bus.reqReady, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      #1;
      check("flush_no_rsp", bus.rspValid, 0);
    end
    check("flush_acc", bus.fflagsAcc, acc_model);

    // clearFlags without handshake
    tick(); bus.clearFlags = 1'b1;
    tick(); bus.clearFlags = 1'b0;
    #1;
    acc_model = 5'd0;
    check("clear_acc", bus.fflagsAcc, acc_model);

    // Sqrt with unitDone 9 cycles after unitStart, then back-pressure
    sq_res = 32'h3FB5_04F3;
    tick();
    bus.reqValid = 1'b1; bus.reqUnit = U_SQRT; bus.rspReady = 1'b0;
    bus.unitFpResult = sq_res; bus.unitIntResult = 32'h55; bus.unitFlags = 5'h01;
    bus.unitWriteFlags = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      bus.reqValid = 1'b0;
      bus.unitDone = (i == 10);
      #1;
      check("sqrt_start", bus.unitStart, (i == 1));
      check("sqrt_no_rsp", bus.rspValid, 0);
    end
    tick();
    bus.unitDone = 1'b0; bus.unitFpResult = 32'h0; bus.unitFlags = 5'h0;
    bus.reqValid = 1'b1; bus.reqUnit = U_MOVE;
    #1;
    check("sqrt_rsp_valid", bus.rspValid, 1);
    check("sqrt_rsp_fp", bus.rspFpResult, sq_res);
    check("sqrt_rsp_int", bus.rspIntResult, 32'h55);
    for (int k = 1; k <= 9; k++) begin
      tick();
      #1;
      check("bp_rsp_valid", bus.rspValid, 1);
      check("bp_rsp_fp", bus.rspFpResult, sq_res);
      check("bp_rsp_flags", bus.rspFlags, 5'h01);
      check("bp_req_ready", bus.reqReady, 0);
      check("bp_op_unit", bus.opUnit, U_SQRT);
    end
    tick();
    bus.reqValid = 1'b0; bus.rspReady = 1'b1;
    #1;
    check("bp_release_valid", bus.rspValid, 1);
    acc_model = acc_model | 5'h01;
    tick();
    #1;
    check("sqrt_req_ready_after", bus.reqReady, 1);
    check("sqrt_acc", bus.fflagsAcc, acc_model);

    // Reset mid-MulAdd (during the unitStart cycle)
    tick();
    bus.reqValid = 1'b1; bus.reqUnit = U_MULADD; bus.reqSrc1 = 32'h1234_5678;
    tick();
    bus.reqValid = 1'b0;
    #1;
    check("ma_unit_start", bus.unitStart, 1);
    rst = 1'b0;
    #1;
    check("arst_state", dbg_state, 0);
    check("arst_unit_start", bus.unitStart, 0);
    check("arst_req_ready", bus.reqReady, 1);
    check("arst_op_src1", bus.opSrc1, 0);
    check("arst_op_unit", bus.opUnit, 0);
    check("arst_rsp_fp", bus.rspFpResult, 0);
    check("arst_acc", bus.fflagsAcc, 0);
    acc_model = 5'd0;
    tick(); rst = 1'b1;
    do_op(U_MOVE, 1, 32'h4000_0000, 5'h00, 1'b0, 1'b0);

    // Unknown unit: zero response, no flag write
    do_op(U_UNK, 1, 32'hDEAD_BEEF, 5'h1F, 1'b1, 1'b0);
    check("unk_acc", bus.fflagsAcc, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fp_unit_sequencer.md
# fp_unit_sequencer

Parametrised control shell for the floating-point execution cluster. It accepts one FP operation at a time over a valid/ready request channel and latches its operands. It sequences the operation onto the combinational and multi-cycle FP datapath units, counting fixed latencies or waiting on a done strobe. The result is returned over a valid/ready response channel, and exception flags are OR-ed into a sticky accumulator. It sits between the FP issue stage and the FP datapath units, replacing the single-cycle mux/enable glue with a FLEN-generic, back-pressurable, flushable sequencer.

## Interface
Parameters:
- FLEN, 32: FP operand/result width (32 or 64).
- XLEN, 32: integer source/result width.
- MULADD_CYCLES, 3: fixed latency of the MulAdd unit, in cycles (≥1).
- DIV_CYCLES, 14: fixed latency of the Div unit, in cycles (≥1).

Ports:
- clk  in  1  clock. One clock; reset is asynchronous and active-low.
- rst  in  1  asynchronous, active-low reset.
- reqValid / reqReady  in / out  1  request handshake.
- reqUnit  in  FpUnitType  selects the target unit.
- reqRm  in  3  rounding mode.
- reqSrc1, reqSrc2, reqSrc3  in  FLEN  FP operands.
- reqIntSrc  in  XLEN  integer operand.
- flush  in  1  abort the in-flight operation.
- unitStart  out  1  one-cycle start pulse to the selected unit.
- unitFlush  out  1  equals flush, gated by state≠IDLE.
- opUnit, opRm, opSrc1..3, opIntSrc  out  as req*  latched operands, stable from accept until return to IDLE.
- unitDone  in  1  completion strobe from the Sqrt unit.
- unitFpResult  in  FLEN; unitIntResult  in  XLEN; unitFlags  in  5; unitWriteFlags  in  1.
- rspValid / rspReady  out / in  1  response handshake.
- rspFpResult  out  FLEN; rspIntResult  out  XLEN; rspFlags  out  5; rspWriteFlags  out  1.
- clearFlags  in  1  clears the accumulator.
- fflagsAcc  out  5  sticky accrued flags {NV,DZ,OF,UF,NX}.

## Operation
States: IDLE, EXEC, WAIT_DONE, RESP.
- **IDLE**:
  - reqReady = !flush.
  - On reqValid&&reqReady: latch op* and go to EXEC.
  - Latency L is set by unit: Move/Classifier/Sign/Comparator/unknown → 1; MulAdd → MULADD_CYCLES; Div → DIV_CYCLES; Sqrt → variable.
  - The counter is loaded with L−1.
- **EXEC**:
  - unitStart is high on the first EXEC cycle only.
  - Fixed L: when the counter is 0, capture unit* into rsp* registers and go to RESP; otherwise decrement.
  - Sqrt: go to WAIT_DONE after the first cycle.
- **WAIT_DONE**: capture unit* when unitDone=1 (never in the same cycle as unitStart), then go to RESP.
- **RESP**:
  - rspValid=1, with data held stable.
  - On rspReady: go to IDLE.
  - Accumulation: fflagsAcc ← (clearFlags ? 0 : fflagsAcc) | (rspWriteFlags ? rspFlags : 0).
- **Unknown reqUnit**: respond with all-zero data and rspWriteFlags=0.
- **clearFlags without handshake**: fflagsAcc ← 0.
- **flush** (any state other than IDLE): next state is IDLE. The rsp* registers are not updated, no accumulation occurs (this also applies to a simultaneous RESP handshake: flush wins, and the response counts as dropped), and the counter is zeroed.
- **Counter width**: $clog2(max(MULADD_CYCLES,DIV_CYCLES)+1).
- **Width rules**: FP results are passed through unchanged at FLEN width. When FLEN>32, FLEN=32 results are not NaN-boxed here; the units own NaN-boxing.

## Timing
- Reset values:
  - state IDLE, so reqReady=1.
  - rspValid=0, unitStart=0, unitFlush=0.
  - rsp* = 0, op* = 0, fflagsAcc = 0, counter = 0.
- Reset mid-operation aborts immediately and asynchronously; no response is produced.
- Accept in cycle T gives: unitStart at T+1, result capture at the end of T+L, rspValid from T+L+1.
- Sqrt: if unitDone is seen in cycle D, rspValid rises at D+1.
- reqReady is low from T+1 until the cycle after the response handshake (or after a flush). Maximum throughput is one operation per L+2 cycles.
- Response back-pressure is unbounded; rsp* and op* are held.

## Test plan
- **Move**: FLEN=32, Move with reqIntSrc=0x3F800000 accepted at T → unitStart at T+1; rspValid at T+2 with rspFpResult=0x3F800000 and rspWriteFlags=0; fflagsAcc stays 0.
- **Div**: DIV_CYCLES=14, Div accepted at T → rspValid exactly at T+15; reqReady low from T+1 to T+15 while rspReady=1; reqReady=1 at T+16.
- **Flush mid-Div**: flush at T+5 → unitFlush high at T+5; state IDLE and reqReady=1 at T+6; rspValid never rises; fflagsAcc unchanged.
- **Flag accumulation**: responses with flags 0x01 then 0x10 give fflagsAcc=0x11; a third response with 0x04, handshaken in the same cycle as clearFlags, gives fflagsAcc=0x04.
- **Sqrt and back-pressure**: unitDone asserted 9 cycles after unitStart → rspValid one cycle later; hold rspReady=0 for 10 cycles → rsp* stable, reqValid ignored, reqReady=0.
- **Reset and unknown unit**: deassert rst mid-MulAdd → all outputs at reset values, then a normal request is accepted. An unknown reqUnit → zero response at T+2 with rspWriteFlags=0.
